// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit
// Iterative RV32M multiply/divide unit that sits after the register file.
// It takes the rs1/rs2 read data, computes one result bit per clock and
// hands back a 32-bit result plus the destination register for writeback.
// Control stalls the datapath while busy_o is high. It writes the register
// file on the done_o pulse.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   start_i      request, accepted only while idle
//   funct3_i     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU
//   operand_a_i  rs1 data (multiplicand / dividend)
//   operand_b_i  rs2 data (multiplier / divisor)
//   rd_addr_i    destination register
//   busy_o       high from the accept edge until the unit is idle again
//   done_o       one-cycle pulse; result_o and rd_addr_o are valid
//   result_o     result, held until the next completed operation
//   rd_addr_o    destination register of the completed operation
module rv32m_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       operand_a_i,
    input  logic [XLEN-1:0]       operand_b_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [XLEN-1:0]       result_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]      count;
    logic                  is_div;
    logic                  sel_upper;
    logic                  negate_main;
    logic                  negate_rem;
    logic [ADDR_WIDTH-1:0] rd_latched;

    // Shared working registers. For multiply, hi is the upper half of the
    // running product and lo holds the not-yet-consumed multiplier bits.
    // The low product bits shift into lo from the top. For divide, hi is
    // the partial remainder and lo holds the dividend. Quotient bits shift
    // into lo from the bottom. addend holds the multiplicand or the divisor.
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] addend;

    logic            accept;
    logic            last_iter;
    logic            short_cut;
    logic [XLEN-1:0] short_result;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi;
    logic [XLEN-1:0]   mul_lo;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_hi;
    logic [XLEN-1:0]   div_lo;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   final_result;

    assign accept    = (state == IDLE) && start_i;
    assign last_iter = (count == CNT_W'(XLEN - 1));

    // Decode the signedness of the incoming operands. A magnitude is the
    // plain value when unsigned, otherwise the absolute value. Negating
    // 0x80000000 wraps to itself, which is exactly 2^31 as an unsigned
    // magnitude, so the most negative value needs no special case.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (funct3_i[2]) begin
            a_signed = ~funct3_i[0];
            b_signed = ~funct3_i[0];
        end else begin
            a_signed = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
            b_signed = (funct3_i[1:0] == 2'b01);
        end
        a_neg = a_signed & operand_a_i[XLEN-1];
        b_neg = b_signed & operand_b_i[XLEN-1];
        a_mag = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
        b_mag = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    end

    // Divide by zero and signed overflow have fixed answers. They complete
    // straight from IDLE without iterating.
    always_comb begin
        short_cut    = 1'b0;
        short_result = '0;
        if (funct3_i[2]) begin
            if (operand_b_i == '0) begin
                short_cut    = 1'b1;
                short_result = funct3_i[1] ? operand_a_i : {XLEN{1'b1}};
            end else if (!funct3_i[0]
                         && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (operand_b_i == {XLEN{1'b1}})) begin
                short_cut    = 1'b1;
                short_result = funct3_i[1] ? '0 : operand_a_i;
            end
        end
    end

    // One iteration of each algorithm. The multiplier adds into a
    // 33-bit sum and shifts right by one. The carry lands in the top
    // product bit. The divider shifts the next dividend bit into the
    // 33-bit remainder. It subtracts the divisor only when that does not
    // go negative.
    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? addend : {XLEN{1'b0}})};
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo[XLEN-1:1]};
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, addend});
        div_hi    = div_ge ? (div_shift[XLEN-1:0] - addend) : div_shift[XLEN-1:0];
        div_lo    = {lo[XLEN-2:0], div_ge};
        step_hi   = is_div ? div_hi : mul_hi;
        step_lo   = is_div ? div_lo : mul_lo;
    end

    // Apply the signs to the outcome of the final iteration. Then pick the
    // half or the quotient/remainder that the instruction asked for.
    always_comb begin
        product      = {step_hi, step_lo};
        if (negate_main) begin
            product = ~product + 1'b1;
        end
        quotient     = negate_main ? (~step_lo + 1'b1) : step_lo;
        remainder    = negate_rem ? (~step_hi + 1'b1) : step_hi;
        final_result = '0;
        if (is_div) begin
            final_result = sel_upper ? remainder : quotient;
        end else begin
            final_result = sel_upper ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = short_cut ? DONE : CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. The operands and the destination register are
    // captured on accept. After that, activity on the inputs is ignored
    // until the unit is idle again. result_o and rd_addr_o change only on
    // the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            is_div      <= 1'b0;
            sel_upper   <= 1'b0;
            negate_main <= 1'b0;
            negate_rem  <= 1'b0;
            rd_latched  <= '0;
            hi          <= '0;
            lo          <= '0;
            addend      <= '0;
            result_o    <= '0;
            rd_addr_o   <= '0;
        end else if (accept) begin
            count       <= '0;
            is_div      <= funct3_i[2];
            sel_upper   <= funct3_i[2] ? funct3_i[1] : (funct3_i[1:0] != 2'b00);
            negate_main <= a_neg ^ b_neg;
            negate_rem  <= a_neg;
            rd_latched  <= rd_addr_i;
            hi          <= '0;
            lo          <= funct3_i[2] ? a_mag : b_mag;
            addend      <= funct3_i[2] ? b_mag : a_mag;
            if (short_cut) begin
                result_o  <= short_result;
                rd_addr_o <= rd_addr_i;
            end
        end else if (state == CALC) begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= count + 1'b1;
            if (last_iter) begin
                result_o  <= final_result;
                rd_addr_o <= rd_latched;
            end
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit
// Self-checking bench for rv32m_muldiv_unit. Directed corner cases and
// randomized operations are compared against a plain-arithmetic reference
// model of the RV32M rules. The bench also checks the handshake timing:
// latency, busy length and the one-cycle done pulse.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    rv32m_muldiv_unit #(
        .XLEN       (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .funct3_i    (funct3_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .rd_addr_i   (rd_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .rd_addr_o   (rd_addr_o)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // RV32M result computed with 64-bit integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic bit isShortCut(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one operation and scramble the inputs after acceptance. Then
    // wait for done and check latency, busy length, result and destination.
    // With disturb set, a second start is pulsed at iteration 10.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input bit disturb);
        logic [31:0] expected;
        int          exp_lat;
        int          k;
        int          busy_cycles;
        bit          seen;
        expected = refModel(f, a, b);
        exp_lat  = isShortCut(f, a, b) ? 0 : 32;
        @(negedge clk);
        funct3_i    = f;
        operand_a_i = a;
        operand_b_i = b;
        rd_addr_i   = rd;
        start_i     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i     = 1'b0;
        funct3_i    = 3'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        rd_addr_i   = 5'($urandom);
        k           = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (k < 64) begin
            if (busy_o) busy_cycles++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            start_i = (disturb && k == 9);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        if (!seen) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("latency", 64'(k), 64'(exp_lat));
            checkOutput("busy_len", 64'(busy_cycles), 64'(exp_lat + 1));
            checkOutput("result", {32'b0, result_o}, {32'b0, expected});
            checkOutput("rd_addr", {59'b0, rd_addr_o}, {59'b0, rd});
            @(posedge clk);
            @(negedge clk);
            checkOutput("done_pulse", {63'b0, done_o}, 64'd0);
            checkOutput("busy_drop", {63'b0, busy_o}, 64'd0);
            checkOutput("result_hold", {32'b0, result_o}, {32'b0, expected});
        end
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst         = 1'b1;
        start_i     = 1'b0;
        funct3_i    = 3'b000;
        operand_a_i = 32'h0;
        operand_b_i = 32'h0;
        rd_addr_i   = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {63'b0, busy_o}, 64'd0);
        checkOutput("reset_done", {63'b0, done_o}, 64'd0);
        checkOutput("reset_result", {32'b0, result_o}, 64'd0);
        checkOutput("reset_rd", {59'b0, rd_addr_o}, 64'd0);
        rst = 1'b0;

        // Directed corner cases
        applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b0);
        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b0);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd7, 1'b0);
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd8, 1'b0);
        applyStimulus(3'b101, 32'h1234, 32'd0, 5'd10, 1'b0);
        applyStimulus(3'b110, 32'h1234, 32'd0, 5'd11, 1'b0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
        applyStimulus(3'b000, 32'd3, 32'd5, 5'd9, 1'b1);

        // Reset in the middle of a divide
        @(negedge clk);
        funct3_i    = 3'b100;
        operand_a_i = 32'd1000;
        operand_b_i = 32'd3;
        rd_addr_i   = 5'd14;
        start_i     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", {63'b0, busy_o}, 64'd0);
        checkOutput("midreset_done", {63'b0, done_o}, 64'd0);
        checkOutput("midreset_result", {32'b0, result_o}, 64'd0);
        checkOutput("midreset_rd", {59'b0, rd_addr_o}, 64'd0);
        applyStimulus(3'b000, 32'd2, 32'd2, 5'd15, 1'b0);

        // Randomized operations with corner-biased operands
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(f, a, b, 5'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
